dplca_claim_table_ctrl: RTL and testbench
=========================================

// Module: dplca_claim_table_ctrl
// PURPOSE
//  Maintains the D-PLCA TXOP claim table consumed by the 148.8 node-ID allocation FSM.
//  Observes TXOP activity per beacon cycle, refreshes and ages the 2-bit claim entries,
//  and produces dplca_txop_table_upd / dplca_new_age.
//  Sits between the PLCA control/data FSMs (TXOP strobes, rx_cmd) and the allocation FSM.
// PARAMETERS
//  AGING_CYCLES  8    beacon cycles per aging period (>=1)
//  CLAIM_MAX     3    value written to an entry on observed activity (1..3)
// PORTS
//  clk                        in   1    block clock
//  plca_reset                 in   1    asynchronous, active-high reset
//  dplca_en                   in   1    D-PLCA enable; low forces IDLE and clears table
//  dplca_aging                in   1    aging enable (ON=1) from allocation FSM
//  rx_cmd                     in   2    BEACON=00 COMMIT=01 NONE=10
//  txop_end                   in   1    1-cycle strobe: TXOP txop_id has closed
//  txop_id                    in   8    curID of the closing TXOP
//  txop_active                in   1    TXOP carried traffic (valid with txop_end)
//  plca_node_count            in   8    current node count
//  txop_claim_table_unpacked  out  512  entry i at bits [2i+1:2i]
//  dplca_txop_table_upd       out  1    1-cycle pulse: table refreshed
//  dplca_new_age              out  1    aging period boundary; held for one beacon cycle
//  dplca_age_cnt              out  8    beacon cycles since last aging boundary
// BEHAVIOUR
//  Reset: table=0, seen=0, upd=0, new_age=0, age_cnt=0, state=IDLE. All outputs are registered.
//  States:
//   IDLE  -> WAIT_BEACON when dplca_en=1.
//   WAIT_BEACON -> CYCLE on beacon_rise. No table write and no upd on this transition.
//   CYCLE -> CYCLE on beacon_rise (commit).
//  beacon_rise = (rx_cmd==BEACON) && (prev rx_cmd!=BEACON); prev register resets to NONE.
//  dplca_en=0 in any state: at the next edge -> IDLE; table, seen, age_cnt, upd and new_age cleared.
//  CYCLE tracking:
//   txop_end && txop_active sets seen[txop_id].
//   txop_end with txop_id >= plca_node_count is ignored.
//  Commit, at the edge sampling beacon_rise in CYCLE:
//   age_tick = dplca_aging && (age_cnt == AGING_CYCLES-1)
//   for each i:
//    i >= plca_node_count -> entry = 0
//    else seen[i]         -> entry = CLAIM_MAX
//    else age_tick && entry != 0 -> entry = entry - 1 (saturates at 0)
//    else                 -> unchanged
//   seen cleared.
//   age_cnt = age_tick ? 0 : age_cnt+1 (saturates at 255).
//   dplca_new_age = age_tick.
//   dplca_txop_table_upd = 1 for exactly the following cycle.
//  Simultaneous txop_end (active) and beacon_rise: the activity is merged into this commit.
//  dplca_aging=0: age_cnt held at 0 and new_age forced 0 at the next commit; no decrement.
//  plca_node_count change mid-cycle: the value sampled at the commit edge applies.
//  Latency: table, upd and new_age are visible 1 clk after the beacon_rise sample edge.
//  CLAIMING(i) is defined as entry != 0.
//  Reset asserted mid-cycle clears everything immediately (async).
// TESTING
//  T1 reset then dplca_en=1; first beacon -> no upd pulse.
//     Second beacon with txop_active on ids 0,3 -> entries 0,3 = 3, rest 0; upd high 1 clk.
//  T2 aging=1, AGING_CYCLES=8; id 5 active once, then 8 idle cycles.
//     -> new_age on the 8th commit, entry5 3->2; next commit new_age=0.
//  T3 node_count=8; txop_end id 10 active -> ignored.
//     Lower node_count 8->4 with entry6=3 -> entry6=0 at commit.
//  T4 txop_end (id 2, active) on the same clk as beacon_rise -> entry2=3 in that commit.
//  T5 dplca_en dropped mid-cycle -> IDLE next clk, table all 0.
//     plca_reset pulse -> immediate clear, no upd.
//  T6 aging=0 for 20 cycles -> no new_age, no decrement, age_cnt=0.

Source files
------------

// File: rtl/dplca_claim_table_ctrl.sv
// D-PLCA TXOP claim table: records per-node TXOP activity over each beacon cycle,
// refreshes/ages the 2-bit claim entries at every beacon commit, and flags aging boundaries.
module dplca_claim_table_ctrl #(
  parameter int unsigned AGING_CYCLES = 8,
  parameter int unsigned CLAIM_MAX    = 3
) (
  input  logic           clk,
  input  logic           plca_reset,
  input  logic           dplca_en,
  input  logic           dplca_aging,
  input  logic [1:0]     rx_cmd,
  input  logic           txop_end,
  input  logic [7:0]     txop_id,
  input  logic           txop_active,
  input  logic [7:0]     plca_node_count,
  output logic [511:0]   txop_claim_table_unpacked,
  output logic           dplca_txop_table_upd,
  output logic           dplca_new_age,
  output logic [7:0]     dplca_age_cnt
);

  localparam int unsigned N_ENTRIES = 256;
  localparam int unsigned TBL_W     = 2 * N_ENTRIES;
  localparam logic [1:0]  CMD_BEACON = 2'b00;
  localparam logic [1:0]  CMD_NONE   = 2'b10;
  localparam logic [1:0]  CLAIM_VAL  = 2'(CLAIM_MAX);
  localparam logic [7:0]  AGE_LAST   = 8'(AGING_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_BEACON = 2'd1,
    S_CYCLE       = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_prev_cmd;
  logic [TBL_W-1:0]     r_table;
  logic [N_ENTRIES-1:0] r_seen;
  logic                 r_upd;
  logic                 r_new_age;
  logic [7:0]           r_age_cnt;

  logic                 w_beacon_rise;
  logic                 w_txop_hit;
  logic                 w_age_tick;
  logic [N_ENTRIES-1:0] w_seen_merged;
  logic [TBL_W-1:0]     w_table_next;

  assign w_beacon_rise = (rx_cmd == CMD_BEACON) && (r_prev_cmd != CMD_BEACON);
  assign w_txop_hit    = txop_end && txop_active && (txop_id < plca_node_count);
  assign w_age_tick    = dplca_aging && (r_age_cnt == AGE_LAST);

  // Activity closing on the commit edge itself is folded into that commit.
  always_comb begin
    w_seen_merged = r_seen;
    if (w_txop_hit) begin
      w_seen_merged[txop_id] = 1'b1;
    end
  end

  always_comb begin
    w_table_next = r_table;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (9'(i) >= {1'b0, plca_node_count}) begin
        w_table_next[2*i +: 2] = 2'b00;
      end else if (w_seen_merged[i]) begin
        w_table_next[2*i +: 2] = CLAIM_VAL;
      end else if (w_age_tick && (r_table[2*i +: 2] != 2'b00)) begin
        w_table_next[2*i +: 2] = r_table[2*i +: 2] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      r_state    <= S_IDLE;
      r_prev_cmd <= CMD_NONE;
      r_table    <= '0;
      r_seen     <= '0;
      r_upd      <= 1'b0;
      r_new_age  <= 1'b0;
      r_age_cnt  <= 8'd0;
    end else begin
      r_prev_cmd <= rx_cmd;
      r_upd      <= 1'b0;
      if (!dplca_en) begin
        r_state   <= S_IDLE;
        r_table   <= '0;
        r_seen    <= '0;
        r_new_age <= 1'b0;
        r_age_cnt <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_BEACON;
          S_WAIT_BEACON: begin
            if (w_beacon_rise) begin
              r_state <= S_CYCLE;
              r_seen  <= '0;
            end
          end
          S_CYCLE: begin
            if (w_beacon_rise) begin
              r_table   <= w_table_next;
              r_seen    <= '0;
              r_upd     <= 1'b1;
              r_new_age <= w_age_tick;
              if (!dplca_aging || w_age_tick) begin
                r_age_cnt <= 8'd0;
              end else if (r_age_cnt != 8'hFF) begin
                r_age_cnt <= r_age_cnt + 8'd1;
              end
            end else begin
              r_seen <= w_seen_merged;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign txop_claim_table_unpacked = r_table;
  assign dplca_txop_table_upd      = r_upd;
  assign dplca_new_age             = r_new_age;
  assign dplca_age_cnt             = r_age_cnt;

endmodule

// File: tb/tb_dplca_claim_table_ctrl.sv
// Bench for dplca_claim_table_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against an array-based model of the claim table rules.
module tb_dplca_claim_table_ctrl;

  localparam int AGING = 8;
  localparam int CMAX  = 3;

  logic         clk = 1'b0;
  logic         plca_reset;
  logic         dplca_en;
  logic         dplca_aging;
  logic [1:0]   rx_cmd;
  logic         txop_end;
  logic [7:0]   txop_id;
  logic         txop_active;
  logic [7:0]   plca_node_count;
  logic [511:0] tbl;
  logic         upd;
  logic         new_age;
  logic [7:0]   age_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  dplca_claim_table_ctrl #(.AGING_CYCLES(AGING), .CLAIM_MAX(CMAX)) dut (
    .clk                       (clk),
    .plca_reset                (plca_reset),
    .dplca_en                  (dplca_en),
    .dplca_aging               (dplca_aging),
    .rx_cmd                    (rx_cmd),
    .txop_end                  (txop_end),
    .txop_id                   (txop_id),
    .txop_active               (txop_active),
    .plca_node_count           (plca_node_count),
    .txop_claim_table_unpacked (tbl),
    .dplca_txop_table_upd      (upd),
    .dplca_new_age             (new_age),
    .dplca_age_cnt             (age_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entries as plain integers, activity as a flag array.
  int m_tbl[256];
  bit m_seen[256];
  int m_mode;   // 0 disabled, 1 waiting for first beacon, 2 tracking cycles
  int m_prev;
  bit m_upd;
  bit m_new_age;
  int m_age;

  task automatic m_clear();
    for (int i = 0; i < 256; i++) begin
      m_tbl[i]  = 0;
      m_seen[i] = 1'b0;
    end
    m_age     = 0;
    m_upd     = 1'b0;
    m_new_age = 1'b0;
  endtask

  task automatic m_step();
    bit rise;
    bit aged;
    int nc;
    nc    = int'(plca_node_count);
    rise  = (rx_cmd == 2'b00) && (m_prev != 0);
    m_prev = int'(rx_cmd);
    m_upd = 1'b0;
    if (!dplca_en) begin
      m_clear();
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) m_mode = 2;
    end else begin
      if (txop_end && txop_active && int'(txop_id) < nc) m_seen[txop_id] = 1'b1;
      if (rise) begin
        aged = dplca_aging && (m_age == AGING - 1);
        for (int i = 0; i < 256; i++) begin
          if (i >= nc) m_tbl[i] = 0;
          else if (m_seen[i]) m_tbl[i] = CMAX;
          else if (aged && m_tbl[i] > 0) m_tbl[i] = m_tbl[i] - 1;
          m_seen[i] = 1'b0;
        end
        if (!dplca_aging || aged) m_age = 0;
        else if (m_age < 255) m_age = m_age + 1;
        m_new_age = aged;
        m_upd     = 1'b1;
      end
    end
  endtask

  always @(posedge clk or posedge plca_reset) begin
    if (plca_reset) begin
      m_clear();
      m_mode = 0;
      m_prev = 2;
    end else begin
      m_step();
    end
  end

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ent(input int i);
    return int'(tbl[2*i +: 2]);
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [511:0] e;
    if (cmp_en && !plca_reset) begin
      for (int i = 0; i < 256; i++) e[2*i +: 2] = 2'(m_tbl[i]);
      check("cyc_table", tbl, e);
      check("cyc_upd", 512'(upd), 512'(m_upd));
      check("cyc_new_age", 512'(new_age), 512'(m_new_age));
      check("cyc_age_cnt", 512'(age_cnt), 512'(m_age));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic txop(input int id);
    txop_end    = 1'b1;
    txop_id     = 8'(id);
    txop_active = 1'b1;
    tick();
    txop_end    = 1'b0;
    txop_active = 1'b0;
  endtask

  // One NONE cycle, then a BEACON cycle; returns just after the commit edge.
  task automatic commit();
    rx_cmd = 2'b10;
    tick();
    rx_cmd = 2'b00;
    tick();
  endtask

  initial begin
    plca_reset = 1'b1; dplca_en = 1'b0; dplca_aging = 1'b0; rx_cmd = 2'b10;
    txop_end = 1'b0; txop_id = 8'd0; txop_active = 1'b0; plca_node_count = 8'd8;
    repeat (2) tick();
    check("rst_table", tbl, 512'd0);
    check("rst_upd", 512'(upd), 512'd0);
    check("rst_new_age", 512'(new_age), 512'd0);
    check("rst_age_cnt", 512'(age_cnt), 512'd0);
    plca_reset = 1'b0;
    cmp_en = 1'b1;

    // T1: first beacon only synchronises; second commits activity on ids 0 and 3
    dplca_en = 1'b1;
    tick();
    commit();
    check("t1_first_beacon_upd", 512'(upd), 512'd0);
    txop(0);
    txop(3);
    commit();
    check("t1_upd", 512'(upd), 512'd1);
    check("t1_e0", 512'(ent(0)), 512'd3);
    check("t1_e3", 512'(ent(3)), 512'd3);
    check("t1_e1", 512'(ent(1)), 512'd0);
    tick();
    check("t1_upd_one_clk", 512'(upd), 512'd0);

    // T2: aging boundary on the 8th commit after id 5 activity
    dplca_aging = 1'b1;
    txop(5);
    commit();
    check("t2_e5_set", 512'(ent(5)), 512'd3);
    check("t2_age1", 512'(age_cnt), 512'd1);
    for (int k = 2; k <= 8; k++) begin
      commit();
      if (k == 7) check("t2_age7", 512'(age_cnt), 512'd7);
      if (k < 8) check("t2_no_new_age", 512'(new_age), 512'd0);
    end
    check("t2_new_age", 512'(new_age), 512'd1);
    check("t2_e5_aged", 512'(ent(5)), 512'd2);
    check("t2_e0_aged", 512'(ent(0)), 512'd2);
    check("t2_age_wrap", 512'(age_cnt), 512'd0);
    tick();
    check("t2_new_age_held", 512'(new_age), 512'd1);
    commit();
    check("t2_new_age_clear", 512'(new_age), 512'd0);
    check("t2_e5_kept", 512'(ent(5)), 512'd2);

    // T3: out-of-range id ignored; shrinking node count clears upper entries
    txop(10);
    commit();
    check("t3_e10", 512'(ent(10)), 512'd0);
    txop(6);
    commit();
    check("t3_e6_set", 512'(ent(6)), 512'd3);
    plca_node_count = 8'd4;
    commit();
    check("t3_e6_cleared", 512'(ent(6)), 512'd0);
    check("t3_e5_cleared", 512'(ent(5)), 512'd0);
    check("t3_e3_kept", 512'(ent(3)), 512'd2);
    plca_node_count = 8'd8;

    // T4: activity on the beacon edge merges into that commit
    rx_cmd = 2'b10;
    tick();
    rx_cmd = 2'b00; txop_end = 1'b1; txop_id = 8'd2; txop_active = 1'b1;
    tick();
    txop_end = 1'b0; txop_active = 1'b0;
    check("t4_e2", 512'(ent(2)), 512'd3);

    // T5: enable drop clears; async reset clears immediately
    txop(1);
    dplca_en = 1'b0;
    tick();
    check("t5_en_table", tbl, 512'd0);
    check("t5_en_age", 512'(age_cnt), 512'd0);
    dplca_en = 1'b1;
    tick();
    commit();
    check("t5_resync_upd", 512'(upd), 512'd0);
    txop(4);
    commit();
    check("t5_e4", 512'(ent(4)), 512'd3);
    plca_reset = 1'b1;
    #1;
    check("t5_rst_table", tbl, 512'd0);
    check("t5_rst_upd", 512'(upd), 512'd0);
    tick();
    plca_reset = 1'b0;
    tick();
    commit();
    commit();

    // T6: aging disabled holds age at 0 with no decrement
    dplca_aging = 1'b0;
    txop(1);
    commit();
    for (int k = 0; k < 20; k++) begin
      commit();
      check("t6_new_age", 512'(new_age), 512'd0);
      check("t6_age", 512'(age_cnt), 512'd0);
    end
    check("t6_e1", 512'(ent(1)), 512'd3);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rx_cmd      = 2'($urandom_range(0, 2));
      txop_end    = ($urandom_range(0, 9) < 4);
      txop_active = $urandom_range(0, 1) == 1;
      txop_id     = 8'($urandom_range(0, 23));
      if ($urandom_range(0, 19) == 0) plca_node_count = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 29) == 0) dplca_aging = ~dplca_aging;
      dplca_en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 499) == 0) begin
        plca_reset = 1'b1;
        tick();
        plca_reset = 1'b0;
      end
      tick();
    end
    txop_end = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
